// File: rtl/seq_reg_controller_if.sv
// Bus between instruction decode (master) and the register/ALU sequencer (slave).
interface seq_reg_controller_if #(
    parameter int unsigned NREG  = 3,
    parameter int unsigned CNT_W = 4
) ();
    logic                      start;
    logic [2:0]                op;
    logic [$clog2(NREG)-1:0]   dst;
    logic [CNT_W-1:0]          count;
    logic                      mbit;
    logic [2*NREG-1:0]         treg;
    logic [1:0]                talu;
    logic                      mshr;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        output start, op, dst, count, mbit,
        input  treg, talu, mshr, busy, done, err
    );

    modport slave (
        input  start, op, dst, count, mbit,
        output treg, talu, mshr, busy, done, err
    );
endinterface

// File: rtl/seq_reg_controller.sv
// Multi-cycle control sequencer for the shift/add datapath.
// Drives NREG register controls plus ALU op, runs SHL and shift-add MUL sequences
// from an iteration count, start/busy/done handshake, err pulse on illegal requests.
// Optional feature macro: CTRL_MUL_EN (enables op 110 MUL; otherwise 110 is reserved).
module seq_reg_controller #(
    parameter int unsigned NREG  = 3,
    parameter int unsigned CNT_W = 4
) (
    input logic                 clock,
    input logic                 reset,
    seq_reg_controller_if.slave bus
);
    localparam int unsigned DST_W = $clog2(NREG);

    localparam logic [1:0] TREG_CLEAR  = 2'b00;
    localparam logic [1:0] TREG_LOAD   = 2'b01;
    localparam logic [1:0] TREG_HOLD   = 2'b10;
    localparam logic [1:0] TREG_SHIFTL = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StAddStep, StShiftStep} state_e;

    state_e             state_q;
    logic [2:0]         op_q;
    logic [DST_W-1:0]   dst_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               illegal_q;

    logic               req_mul_op;
    logic               req_rsvd;
    logic               req_bad_dst;
    logic               req_illegal;

`ifdef CTRL_MUL_EN
    assign req_mul_op = (bus.op == OP_MUL);
    assign req_rsvd   = (bus.op == OP_RSVD);
`else
    assign req_mul_op = 1'b0;
    assign req_rsvd   = (bus.op == OP_RSVD) || (bus.op == OP_MUL);
    // mbit has no consumer without the multiply sequence
    logic unused_mbit;
    assign unused_mbit = bus.mbit;
`endif

    // NOP never touches a register, so its dst is never out of range
    assign req_bad_dst = (bus.op != OP_NOP) && (int'(bus.dst) >= int'(NREG));
    assign req_illegal = req_rsvd || req_bad_dst;

    // Sequencer state, latched request fields and iteration down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        op_q      <= bus.op;
                        dst_q     <= bus.dst;
                        cnt_q     <= bus.count;
                        illegal_q <= req_illegal;
                        // Illegal or zero-count requests collapse to a single EXEC cycle
                        if (req_illegal || bus.count == '0) begin
                            state_q <= StExec;
                        end else if (bus.op == OP_SHL) begin
                            state_q <= StShiftStep;
                        end else if (req_mul_op) begin
                            state_q <= StAddStep;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    state_q <= StIdle;
                end
`ifdef CTRL_MUL_EN
                StAddStep: begin
                    state_q <= StShiftStep;
                end
`endif
                StShiftStep: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StIdle;
`ifdef CTRL_MUL_EN
                    end else if (op_q == OP_MUL) begin
                        state_q <= StAddStep;
`endif
                    end else begin
                        state_q <= StShiftStep;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    logic [2*NREG-1:0] treg;
    logic [1:0]        dst_code;
    logic [1:0]        talu;
    logic              mshr;
    logic              done;
    logic              err;

    // Control decode from registered state; ADDSTEP also looks at the live mbit
    always_comb begin
        treg     = {NREG{TREG_HOLD}};
        dst_code = TREG_HOLD;
        talu     = ALU_ADD;
        mshr     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StExec: begin
                done = 1'b1;
                err  = illegal_q;
                if (!illegal_q) begin
                    unique case (op_q)
                        OP_CLR: dst_code = TREG_CLEAR;
                        OP_LD: begin
                            dst_code = TREG_LOAD;
                            talu     = ALU_PASS;
                        end
                        OP_ADD: begin
                            dst_code = TREG_LOAD;
                            talu     = ALU_ADD;
                        end
                        OP_SUB: begin
                            dst_code = TREG_LOAD;
                            talu     = ALU_SUB;
                        end
                        // NOP, and SHL/MUL with count=0, hold everything
                        default: dst_code = TREG_HOLD;
                    endcase
                end
            end
`ifdef CTRL_MUL_EN
            StAddStep: begin
                dst_code = bus.mbit ? TREG_LOAD : TREG_HOLD;
            end
`endif
            StShiftStep: begin
                dst_code = TREG_SHIFTL;
                done     = (cnt_q == CNT_W'(1));
`ifdef CTRL_MUL_EN
                mshr     = (op_q == OP_MUL);
`endif
            end
            default: begin
            end
        endcase
        for (int i = 0; i < int'(NREG); i++) begin
            if (int'(dst_q) == i) begin
                treg[2*i +: 2] = dst_code;
            end
        end
    end

    assign bus.treg = treg;
    assign bus.talu = talu;
    assign bus.mshr = mshr;
    assign bus.busy = (state_q != StIdle);
    assign bus.done = done;
    assign bus.err  = err;
endmodule

// File: tb/tb_seq_reg_controller.sv
// Self-checking bench for seq_reg_controller: directed scenarios plus randomized requests,
// each checked cycle by cycle against an expected control-cycle list built from the op rules.
module tb_seq_reg_controller;
    localparam int unsigned NREG  = 3;
    localparam int unsigned CNT_W = 4;
`ifdef CTRL_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    typedef struct packed {
        logic [2*NREG-1:0] treg;
        logic [1:0]        talu;
        logic              mshr;
        logic              done;
        logic              err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    seq_reg_controller_if #(.NREG(NREG), .CNT_W(CNT_W)) bus ();

    seq_reg_controller #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*NREG-1:0] all_hold();
        return {NREG{2'b10}};
    endfunction

    function automatic logic [2*NREG-1:0] with_field(input int idx, input logic [1:0] code);
        logic [2*NREG-1:0] v;
        v = all_hold();
        v[2*idx +: 2] = code;
        return v;
    endfunction

    function automatic exp_t mk(input logic [2*NREG-1:0] t, input logic [1:0] a,
                                input logic m, input logic e);
        exp_t x;
        x.treg = t;
        x.talu = a;
        x.mshr = m;
        x.done = 1'b0;
        x.err  = e;
        return x;
    endfunction

    function automatic bit is_illegal(input int op, input int dst);
        return (op == 7) || (op == 6 && !MulEn) || (op != 0 && dst >= int'(NREG));
    endfunction

    // Expected list of control cycles for one accepted request
    function automatic void build(input int op, input int dst, input int cnt,
                                  input logic [15:0] mb);
        exp_t e;
        q.delete();
        if (is_illegal(op, dst)) begin
            q.push_back(mk(all_hold(), 2'b00, 1'b0, 1'b1));
        end else begin
            case (op)
                1: q.push_back(mk(with_field(dst, 2'b00), 2'b00, 1'b0, 1'b0));
                2: q.push_back(mk(with_field(dst, 2'b01), 2'b10, 1'b0, 1'b0));
                3: q.push_back(mk(with_field(dst, 2'b01), 2'b00, 1'b0, 1'b0));
                4: q.push_back(mk(with_field(dst, 2'b01), 2'b01, 1'b0, 1'b0));
                5: begin
                    if (cnt == 0) q.push_back(mk(all_hold(), 2'b00, 1'b0, 1'b0));
                    for (int i = 0; i < cnt; i++)
                        q.push_back(mk(with_field(dst, 2'b11), 2'b00, 1'b0, 1'b0));
                end
                6: begin
                    if (cnt == 0) q.push_back(mk(all_hold(), 2'b00, 1'b0, 1'b0));
                    for (int i = 0; i < cnt; i++) begin
                        q.push_back(mk(mb[i] ? with_field(dst, 2'b01) : all_hold(),
                                       2'b00, 1'b0, 1'b0));
                        q.push_back(mk(with_field(dst, 2'b11), 2'b00, 1'b1, 1'b0));
                    end
                end
                default: q.push_back(mk(all_hold(), 2'b00, 1'b0, 1'b0));
            endcase
        end
        e = q.pop_back();
        e.done = 1'b1;
        q.push_back(e);
    endfunction

    task automatic idle_check(input string tag);
        check_eq({tag, ".treg"}, 32'(bus.treg), 32'(all_hold()));
        check_eq({tag, ".talu"}, 32'(bus.talu), 32'd0);
        check_eq({tag, ".mshr"}, 32'(bus.mshr), 32'd0);
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ".done"}, 32'(bus.done), 32'd0);
        check_eq({tag, ".err"},  32'(bus.err),  32'd0);
    endtask

    task automatic cycle_check(input string tag, input exp_t e);
        check_eq({tag, ".treg"}, 32'(bus.treg), 32'(e.treg));
        check_eq({tag, ".talu"}, 32'(bus.talu), 32'(e.talu));
        check_eq({tag, ".mshr"}, 32'(bus.mshr), 32'(e.mshr));
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check_eq({tag, ".done"}, 32'(bus.done), 32'(e.done));
        check_eq({tag, ".err"},  32'(bus.err),  32'(e.err));
    endtask

    // Present a request in an idle cycle, then check every control cycle; optionally keep
    // start asserted with scrambled fields while busy to show it is ignored.
    task automatic run_op(input string tag, input int op, input int dst, input int cnt,
                          input logic [15:0] mb, input bit hold_start);
        bit mul_seq;
        @(posedge clock); #2;
        bus.start = 1'b1;
        bus.op    = 3'(op);
        bus.dst   = 2'(dst);
        bus.count = 4'(cnt);
        bus.mbit  = 1'($urandom);
        #2 idle_check({tag, ".idle"});
        build(op, dst, cnt, mb);
        mul_seq = (op == 6) && !is_illegal(op, dst) && cnt != 0;
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clock); #2;
            bus.start = hold_start;
            if (hold_start) begin
                bus.op    = 3'($urandom);
                bus.dst   = 2'($urandom);
                bus.count = 4'($urandom);
            end
            bus.mbit = (mul_seq && (k % 2 == 0)) ? mb[k/2] : 1'($urandom);
            #2 cycle_check($sformatf("%s.c%0d", tag, k), q[k]);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.dst   = '0;
        bus.count = '0;
        bus.mbit  = 1'b0;
        repeat (2) @(posedge clock);
        #2 idle_check("reset");
        reset = 1'b0;

        // Reset during the third shift cycle of SHL count=5
        @(posedge clock); #2;
        bus.start = 1'b1; bus.op = 3'd5; bus.dst = 2'd0; bus.count = 4'd5;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #2;
            bus.start = 1'b0;
            #1 check_eq($sformatf("rstseq.c%0d.treg", k), 32'(bus.treg),
                        32'(with_field(0, 2'b11)));
        end
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        idle_check("rstseq.after");
        @(posedge clock); #2 idle_check("rstseq.after2");

        run_op("add_d2", 3, 2, 0, 16'h0, 1'b0);
        run_op("shl3", 5, 0, 3, 16'h0, 1'b1);
        run_op("mul4", 6, 1, 4, 16'b1101, 1'b0);
        run_op("rsvd", 7, 0, 0, 16'h0, 1'b0);
        run_op("clr_bad", 1, 3, 0, 16'h0, 1'b0);
        run_op("mul_cfg", 6, 0, 2, 16'h3, 1'b0);
        run_op("shl0", 5, 1, 0, 16'h0, 1'b0);
        run_op("mul0", 6, 1, 0, 16'h0, 1'b0);
        run_op("shl15", 5, 2, 15, 16'h0, 1'b0);
        run_op("ld", 2, 0, 7, 16'h0, 1'b0);
        run_op("sub", 4, 1, 0, 16'h0, 1'b1);
        run_op("nop_d3", 0, 3, 0, 16'h0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int op;
            int cnt;
            op  = int'($urandom_range(0, 7));
            cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(0, 4));
            run_op($sformatf("rnd%0d", n), op, int'($urandom_range(0, 3)), cnt,
                   16'($urandom), 1'($urandom));
        end

        @(posedge clock); #2 idle_check("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
